// File: rtl/pc_word_assembler_pkg.sv
// Shared constants and state encoding for the PC-word assembler.
package PCWordPkg;

  localparam int unsigned PC_WORD_W   = 32;
  localparam logic [31:0] PC_NOP_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/pc_word_assembler_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [N-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + N'(1);
    end
  end

endmodule

// File: rtl/pc_word_assembler.sv
// Packs an 8-bit host byte stream into NPCout-bit PC words, drops NOP padding.
// Optional idle-timeout resync of partial words: define PC_WORD_TIMEOUT_EN.
module pc_word_assembler
  import PCWordPkg::*;
#(
  parameter int unsigned       NPCout    = PC_WORD_W,
  parameter int unsigned       MSB_FIRST = 1,
  parameter logic [NPCout-1:0] NOP_WORD  = NPCout'(PC_NOP_WORD),
  parameter int unsigned       Ncnt      = 16,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_in_v,
  input  logic [7:0]        byte_in_d,
  output logic              byte_in_a,
  output logic              word_out_v,
  output logic [NPCout-1:0] word_out_d,
  input  logic              word_out_a,
  output logic [Ncnt-1:0]   nop_count,
  output logic [Ncnt-1:0]   timeout_count
);

  localparam int unsigned NB = NPCout / 8;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  if ((NPCout % 8 != 0) || (NPCout == 0) || (TIMEOUT == 0)) begin : g_bad_params
    $error("pc_word_assembler: NPCout must be a non-zero multiple of 8, TIMEOUT >= 1");
  end

  state_t            state;
  logic [IW-1:0]     idx;
  logic [NPCout-1:0] sr;
  logic [NPCout-1:0] assembled;
  logic              accept;
  logic              last;
  logic              is_nop;
  logic              nop_inc;

  assign byte_in_a = byte_in_v & ((state == FILL) | word_out_a);
  assign accept    = byte_in_a;
  assign last      = (idx == IW'(NB - 1));
  assign is_nop    = (assembled == NOP_WORD);
  assign nop_inc   = accept & last & is_nop;

  // sr and idx are already zero while in HOLD, so a byte taken on the ack
  // cycle lands in slot 0 through the same placement path.
  always_comb begin
    assembled = sr;
    for (int unsigned i = 0; i < NB; i++) begin
      if (idx == IW'(i)) begin
        assembled[((MSB_FIRST != 0) ? (NB - 1 - i) : i) * 8 +: 8] = byte_in_d;
      end
    end
  end

`ifdef PC_WORD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;
  logic          timeout_hit;

  assign timeout_hit = (state == FILL) && (idx != '0) && !accept &&
                       (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (accept || timeout_hit) begin
      timer <= '0;
    end else if ((state == FILL) && (idx != '0)) begin
      timer <= timer + TW'(1);
    end
  end

  sat_counter #(.N(Ncnt)) u_timeout_count (
    .clk   (clk),
    .reset (reset),
    .inc   (timeout_hit),
    .count (timeout_count)
  );
`else
  assign timeout_count = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      idx        <= '0;
      sr         <= '0;
      word_out_v <= 1'b0;
      word_out_d <= '0;
    end else if (accept) begin
      if (last) begin
        idx <= '0;
        sr  <= '0;
        if (is_nop) begin
          state      <= FILL;
          word_out_v <= 1'b0;
        end else begin
          state      <= HOLD;
          word_out_v <= 1'b1;
          word_out_d <= assembled;
        end
      end else begin
        idx        <= idx + IW'(1);
        sr         <= assembled;
        state      <= FILL;
        word_out_v <= 1'b0;
      end
    end else if ((state == HOLD) && word_out_a) begin
      state      <= FILL;
      word_out_v <= 1'b0;
    end
`ifdef PC_WORD_TIMEOUT_EN
    else if (timeout_hit) begin
      idx <= '0;
      sr  <= '0;
    end
`endif
  end

  sat_counter #(.N(Ncnt)) u_nop_count (
    .clk   (clk),
    .reset (reset),
    .inc   (nop_inc),
    .count (nop_count)
  );

endmodule

// File: tb/tb_pc_word_assembler.sv
// Directed-vector bench for pc_word_assembler (MSB-first and LSB-first instances).
module tb_pc_word_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_in_v;
  logic [7:0]  byte_in_d;
  logic        word_out_a;

  logic        a1, v1, a0, v0;
  logic [31:0] d1, d0;
  logic [15:0] nop1, nop0, to1, to0;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  int          c1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pc_word_assembler #(
    .NPCout(32), .MSB_FIRST(1), .NOP_WORD(32'hFFFF_FFFF), .Ncnt(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .byte_in_v(byte_in_v), .byte_in_d(byte_in_d), .byte_in_a(a1),
    .word_out_v(v1), .word_out_d(d1), .word_out_a(word_out_a),
    .nop_count(nop1), .timeout_count(to1)
  );

  pc_word_assembler #(
    .NPCout(32), .MSB_FIRST(0), .NOP_WORD(32'hFFFF_FFFF), .Ncnt(16), .TIMEOUT(8)
  ) dut_lsb (
    .clk(clk), .reset(reset),
    .byte_in_v(byte_in_v), .byte_in_d(byte_in_d), .byte_in_a(a0),
    .word_out_v(v0), .word_out_d(d0), .word_out_a(word_out_a),
    .nop_count(nop0), .timeout_count(to0)
  );

  // Record every word transfer (v & a just before the rising edge).
  always @(negedge clk) begin
    if (!reset && v1 && word_out_a) begin q1.push_back(d1); c1.push_back(cyc); end
    if (!reset && v0 && word_out_a) q0.push_back(d0);
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    byte_in_v = 1'b1;
    byte_in_d = b;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (a1) done = 1;
      @(posedge clk);
      #1;
    end
    vec++;
    if (!done) begin
      miss++;
      $display("FAIL send_byte_timeout: byte %h not accepted, byte_in_a=%b required 1", b, a1);
    end
    byte_in_v = 1'b0;
  endtask

  task automatic clear_q();
    q1.delete(); q0.delete(); c1.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; byte_in_v = 1'b0; byte_in_d = 8'h00; word_out_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (v1 !== 1'b0)      begin miss++; $display("FAIL reset_v: got %b want 0", v1); end
    vec++; if (d1 !== 32'h0)     begin miss++; $display("FAIL reset_d: got %h want 00000000", d1); end
    vec++; if (nop1 !== 16'h0)   begin miss++; $display("FAIL reset_nop: got %0d want 0", nop1); end
    vec++; if (to1 !== 16'h0)    begin miss++; $display("FAIL reset_timeout: got %0d want 0", to1); end
    vec++; if (a1 !== 1'b0)      begin miss++; $display("FAIL reset_a_idle: got %b want 0", a1); end
    byte_in_v = 1'b1; #1;
    vec++; if (a1 !== 1'b1)      begin miss++; $display("FAIL reset_a_fill: got %b want 1", a1); end
    byte_in_v = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first();
    clear_q(); word_out_a = 1'b1;
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    @(negedge clk);
    vec++; if (v1 !== 1'b1) begin miss++; $display("FAIL msb_latency_v: got %b want 1", v1); end
    vec++; if (d1 !== 32'h12345678) begin miss++; $display("FAIL msb_word: got %h want 12345678", d1); end
    @(negedge clk);
    vec++; if (v1 !== 1'b0) begin miss++; $display("FAIL msb_single_pulse: got %b want 0", v1); end
    vec++; if (q1.size() !== 1) begin miss++; $display("FAIL msb_count: got %0d words want 1", q1.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_lsb_first();
    clear_q(); word_out_a = 1'b1;
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    repeat (2) @(posedge clk); #1;
    vec++;
    if (q0.size() !== 1 || q0[0] !== 32'h78563412) begin
      miss++; $display("FAIL lsb_word: got %0d words first %h want 1 word 78563412",
                       q0.size(), (q0.size() > 0) ? q0[0] : 32'hx);
    end
  endtask

  task automatic test_nop_drop();
    clear_q(); word_out_a = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    repeat (2) @(posedge clk); #1;
    vec++; if (q1.size() !== 0) begin miss++; $display("FAIL nop_no_output: got %0d words want 0", q1.size()); end
    vec++; if (nop1 !== 16'd1) begin miss++; $display("FAIL nop_count: got %0d want 1", nop1); end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    repeat (2) @(posedge clk); #1;
    vec++;
    if (q1.size() !== 1 || q1[0] !== 32'h01020304) begin
      miss++; $display("FAIL nop_then_word: got %0d words first %h want 1 word 01020304",
                       q1.size(), (q1.size() > 0) ? q1[0] : 32'hx);
    end
    vec++; if (nop0 !== 16'd1) begin miss++; $display("FAIL nop_count_lsb: got %0d want 1", nop0); end
  endtask

  task automatic test_stall();
    int bad_a = 0, bad_hold = 0;
    clear_q(); word_out_a = 1'b0;
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    byte_in_v = 1'b1; byte_in_d = 8'hB1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a1 !== 1'b0) bad_a++;
      if (v1 !== 1'b1 || d1 !== 32'hA1A2A3A4) bad_hold++;
      @(posedge clk); #1;
    end
    vec++; if (bad_a != 0) begin miss++; $display("FAIL stall_byte_a: high in %0d of 5 cycles want 0", bad_a); end
    vec++; if (bad_hold != 0) begin miss++; $display("FAIL stall_hold: word unstable in %0d of 5 cycles want 0", bad_hold); end
    word_out_a = 1'b1;
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3); send_byte(8'hB4);
    repeat (2) @(posedge clk); #1;
    vec++;
    if (q1.size() !== 2 || q1[0] !== 32'hA1A2A3A4 || q1[1] !== 32'hB1B2B3B4) begin
      miss++; $display("FAIL stall_words: got %0d words [%h %h] want [a1a2a3a4 b1b2b3b4]",
                       q1.size(), (q1.size() > 0) ? q1[0] : 32'hx, (q1.size() > 1) ? q1[1] : 32'hx);
    end
  endtask

  function automatic logic [31:0] word_of(input int k, input logic [7:0] base);
    logic [7:0] b;
    b = base + 8'(4 * k);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic test_random_ack();
    bit done = 0;
    int bad = 0;
    clear_q();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic [31:0] w;
          w = word_of(k, 8'h20);
          for (int j = 3; j >= 0; j--) send_byte(w[j*8 +: 8]);
        end
        done = 1;
      end
      begin
        while (!done) begin
          word_out_a = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    word_out_a = 1'b1;
    repeat (4) @(posedge clk); #1;
    for (int k = 0; k < 8; k++)
      if (k >= q1.size() || q1[k] !== word_of(k, 8'h20)) bad++;
    vec++;
    if (q1.size() !== 8 || bad != 0) begin
      miss++; $display("FAIL random_ack_order: got %0d words, %0d out of order, want 8 words 0 wrong", q1.size(), bad);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    clear_q(); word_out_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] w;
      w = word_of(k, 8'h40);
      for (int j = 3; j >= 0; j--) send_byte(w[j*8 +: 8]);
    end
    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < 8; k++)
      if (k >= q1.size() || q1[k] !== word_of(k, 8'h40)) bad++;
    vec++;
    if (q1.size() !== 8 || bad != 0) begin
      miss++; $display("FAIL b2b_words: got %0d words, %0d wrong, want 8 words 0 wrong", q1.size(), bad);
    end
    vec++;
    if (c1.size() !== 8 || (c1[7] - c1[0]) != 28) begin
      miss++; $display("FAIL b2b_throughput: got %0d cycles for 7 word gaps want 28",
                       (c1.size() == 8) ? (c1[7] - c1[0]) : -1);
    end
  endtask

`ifdef PC_WORD_TIMEOUT_EN
  task automatic test_timeout();
    clear_q(); word_out_a = 1'b1;
    send_byte(8'hAA); send_byte(8'hBB);
    repeat (7) @(posedge clk); #1;
    vec++; if (to1 !== 16'd0) begin miss++; $display("FAIL timeout_early: got %0d want 0", to1); end
    @(posedge clk); #1;
    vec++; if (to1 !== 16'd1) begin miss++; $display("FAIL timeout_count: got %0d want 1", to1); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (2) @(posedge clk); #1;
    vec++;
    if (q1.size() !== 1 || q1[0] !== 32'h11223344) begin
      miss++; $display("FAIL timeout_resync: got %0d words first %h want 1 word 11223344",
                       q1.size(), (q1.size() > 0) ? q1[0] : 32'hx);
    end
  endtask
`else
  task automatic test_no_timeout();
    clear_q(); word_out_a = 1'b1;
    send_byte(8'hAA); send_byte(8'hBB);
    repeat (20) @(posedge clk); #1;
    send_byte(8'hCC); send_byte(8'hDD);
    repeat (2) @(posedge clk); #1;
    vec++;
    if (q1.size() !== 1 || q1[0] !== 32'hAABBCCDD) begin
      miss++; $display("FAIL no_timeout_word: got %0d words first %h want 1 word aabbccdd",
                       q1.size(), (q1.size() > 0) ? q1[0] : 32'hx);
    end
    vec++; if (to1 !== 16'd0) begin miss++; $display("FAIL no_timeout_count: got %0d want 0", to1); end
  endtask
`endif

  task automatic test_reset_mid_word();
    clear_q(); word_out_a = 1'b1;
    send_byte(8'h5A); send_byte(8'h5B);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    vec++; if (nop1 !== 16'd0 || to1 !== 16'd0) begin
      miss++; $display("FAIL reset_mid_counters: got nop=%0d timeout=%0d want 0 0", nop1, to1);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    repeat (2) @(posedge clk); #1;
    vec++;
    if (q1.size() !== 1 || q1[0] !== 32'hC1C2C3C4) begin
      miss++; $display("FAIL reset_mid_word: got %0d words first %h want 1 word c1c2c3c4",
                       q1.size(), (q1.size() > 0) ? q1[0] : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_nop_drop();
    test_stall();
    test_random_ack();
    test_back_to_back();
`ifdef PC_WORD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
